// File: rtl/stdp_pulse_gen.sv
// STDP pairing stage: times pre/post spikes against each other and emits
// one-cycle inc (causal) or dec (anti-causal) pulses to the weight counter.
module stdp_pulse_gen #(
    parameter int unsigned WINDOW = 7,
    localparam int unsigned AGE_W = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             learn_en,
    input  logic             pre_spike,
    input  logic             post_spike,
    output logic             inc,
    output logic             dec,
    output logic [AGE_W-1:0] dt_out
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WINDOW);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

    logic             pre_valid,   post_valid;
    logic [AGE_W-1:0] pre_age,     post_age;
    logic             pre_valid_d, post_valid_d;
    logic [AGE_W-1:0] pre_age_d,   post_age_d;
    logic             inc_d,       dec_d;
    logic [AGE_W-1:0] dt_d;

    // Next-state: age both timers, then let the spike decode override
    always_comb begin
        pre_valid_d  = pre_valid;
        pre_age_d    = pre_age;
        post_valid_d = post_valid;
        post_age_d   = post_age;
        inc_d        = 1'b0;
        dec_d        = 1'b0;
        dt_d         = dt_out;

        if (pre_valid) begin
            if (pre_age == AGE_MAX) begin
                pre_valid_d = 1'b0;
                pre_age_d   = '0;
            end else begin
                pre_age_d = pre_age + AGE_ONE;
            end
        end

        if (post_valid) begin
            if (post_age == AGE_MAX) begin
                post_valid_d = 1'b0;
                post_age_d   = '0;
            end else begin
                post_age_d = post_age + AGE_ONE;
            end
        end

        if (!learn_en) begin
            pre_valid_d  = 1'b0;
            pre_age_d    = '0;
            post_valid_d = 1'b0;
            post_age_d   = '0;
        end else if (pre_spike && post_spike) begin
            // Coincident spikes: d=0 never pairs, both stay available
            pre_valid_d  = 1'b1;
            pre_age_d    = AGE_ONE;
            post_valid_d = 1'b1;
            post_age_d   = AGE_ONE;
        end else if (post_spike) begin
            if (pre_valid) begin
                inc_d       = 1'b1;
                dt_d        = pre_age;
                pre_valid_d = 1'b0;
                pre_age_d   = '0;
            end
            post_valid_d = 1'b1;
            post_age_d   = AGE_ONE;
        end else if (pre_spike) begin
            if (post_valid) begin
                dec_d        = 1'b1;
                dt_d         = post_age;
                post_valid_d = 1'b0;
                post_age_d   = '0;
            end
            pre_valid_d = 1'b1;
            pre_age_d   = AGE_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_valid  <= 1'b0;
            pre_age    <= '0;
            post_valid <= 1'b0;
            post_age   <= '0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            dt_out     <= '0;
        end else begin
            pre_valid  <= pre_valid_d;
            pre_age    <= pre_age_d;
            post_valid <= post_valid_d;
            post_age   <= post_age_d;
            inc        <= inc_d;
            dec        <= dec_d;
            dt_out     <= dt_d;
        end
    end

endmodule

// File: tb/tb_stdp_pulse_gen.sv
// Bench for stdp_pulse_gen: timestamp-based pairing model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_stdp_pulse_gen;

    localparam int unsigned WINDOW = 7;
    localparam int unsigned AGE_W  = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             learn_en = 1'b0;
    logic             pre_spike = 1'b0;
    logic             post_spike = 1'b0;
    logic             inc, dec;
    logic [AGE_W-1:0] dt_out;

    int n_cmp  = 0;
    int n_fail = 0;

    stdp_pulse_gen #(.WINDOW(WINDOW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .learn_en   (learn_en),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .inc        (inc),
        .dec        (dec),
        .dt_out     (dt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remember the cycle stamp of the latest unconsumed spike per side
    int cyc = 0;
    int pre_t = 0, post_t = 0;
    bit pre_ok = 0, post_ok = 0;
    int exp_inc = 0, exp_dec = 0, exp_dt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_ok = 0; post_ok = 0;
            exp_inc = 0; exp_dec = 0; exp_dt = 0;
        end else begin
            exp_inc = 0; exp_dec = 0;
            if (!learn_en) begin
                pre_ok = 0; post_ok = 0;
            end else if (pre_spike && post_spike) begin
                pre_ok = 1; pre_t = cyc;
                post_ok = 1; post_t = cyc;
            end else if (post_spike) begin
                if (pre_ok && (cyc - pre_t) >= 1 && (cyc - pre_t) <= int'(WINDOW)) begin
                    exp_inc = 1; exp_dt = cyc - pre_t; pre_ok = 0;
                end
                post_ok = 1; post_t = cyc;
            end else if (pre_spike) begin
                if (post_ok && (cyc - post_t) >= 1 && (cyc - post_t) <= int'(WINDOW)) begin
                    exp_dec = 1; exp_dt = cyc - post_t; post_ok = 0;
                end
                pre_ok = 1; pre_t = cyc;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        check("model_inc", int'(inc), exp_inc);
        check("model_dec", int'(dec), exp_dec);
        check("model_dt", int'(dt_out), exp_dt);
        if (inc && dec) check("exclusive", 1, 0);
    end

    // Drive one cycle of inputs; returns just after the closing edge
    task automatic step(input bit pr, input bit po, input bit en);
        pre_spike  = pr;
        post_spike = po;
        learn_en   = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1);
    endtask

    task automatic flush();
        step(0, 0, 0);
        step(0, 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_inc", int'(inc), 0);
        check("reset_dec", int'(dec), 0);
        check("reset_dt", int'(dt_out), 0);
        rst_n = 1'b1;
        flush();

        // Causal pair, d=3
        step(1, 0, 1); idle(2); step(0, 1, 1);
        check("ltp_inc", int'(inc), 1);
        check("ltp_dec", int'(dec), 0);
        check("ltp_dt", int'(dt_out), 3);
        idle(1);
        check("ltp_one_cycle", int'(inc), 0);

        // Anti-causal pair at the window edge, d=7
        flush();
        step(0, 1, 1); idle(6); step(1, 0, 1);
        check("ltd_edge_dec", int'(dec), 1);
        check("ltd_edge_dt", int'(dt_out), 7);

        // Just outside the window, d=8
        flush();
        step(0, 1, 1); idle(7); step(1, 0, 1);
        check("ltd_out_dec", int'(dec), 0);
        check("ltd_out_dt_hold", int'(dt_out), 7);

        // Coincident spikes stay pairable
        flush();
        step(1, 1, 1);
        check("coinc_inc", int'(inc), 0);
        check("coinc_dec", int'(dec), 0);
        idle(3); step(0, 1, 1);
        check("coinc_later_inc", int'(inc), 1);
        check("coinc_later_dt", int'(dt_out), 4);

        // Pre consumed by first post
        flush();
        step(1, 0, 1); idle(1); step(0, 1, 1);
        check("consume_first_inc", int'(inc), 1);
        check("consume_first_dt", int'(dt_out), 2);
        idle(1); step(0, 1, 1);
        check("consume_second_inc", int'(inc), 0);

        // Reset mid-window discards the pending pre
        flush();
        step(1, 0, 1); idle(1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_inc", int'(inc), 0);
        check("rst_mid_dt", int'(dt_out), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1); step(0, 1, 1);
        check("rst_after_inc", int'(inc), 0);
        check("rst_after_dt", int'(dt_out), 0);

        // Pre while learning disabled is ignored
        flush();
        step(1, 0, 0); idle(2); step(0, 1, 1);
        check("learn_off_inc", int'(inc), 0);

        // Back-to-back inc then dec
        flush();
        step(1, 0, 1); idle(1); step(0, 1, 1);
        check("chain_inc", int'(inc), 1);
        check("chain_inc_dec", int'(dec), 0);
        step(1, 0, 1);
        check("chain_dec", int'(dec), 1);
        check("chain_dec_inc", int'(inc), 0);
        check("chain_dt", int'(dt_out), 1);

        // Pseudo-random traffic checked against the model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) != 0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
